// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle mult/div sequencer owning HI/LO (clk, reset, req flush, op_valid/op/a/b issue, d_md_use -> busy/stall/hi/lo)
module mdu_sequencer #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW = $clog2(MAXC + 1);
  logic [CW-1:0] count;
  logic [31:0] res_hi, res_lo, mag_a, mag_b, q_u, r_u, quo, rem, n_hi, n_lo;
  logic [63:0] prod_s, prod_u;
  logic is_mul, is_div, sdiv, mt_ok, issue;
  assign busy = count != '0;
  assign is_mul = op == 3'd1 || op == 3'd2;
  assign is_div = op == 3'd3 || op == 3'd4;
  assign sdiv = op == 3'd3;
  assign mt_ok = op_valid & ~req & ~busy;
  assign issue = mt_ok & (is_mul | is_div);
  assign stall = d_md_use & (busy | issue);
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};
  assign mag_a = (sdiv && a[31]) ? -a : a;
  assign mag_b = (sdiv && b[31]) ? -b : b;
  assign q_u = (mag_b == '0) ? '0 : mag_a / mag_b;
  assign r_u = (mag_b == '0) ? '0 : mag_a % mag_b;
  assign quo = (sdiv && (a[31] ^ b[31])) ? -q_u : q_u;
  assign rem = (sdiv && a[31]) ? -r_u : r_u;
  always_comb begin
    n_hi = op == 3'd1 ? prod_s[63:32] : op == 3'd2 ? prod_u[63:32] : b == '0 ? hi : rem;
    n_lo = op == 3'd1 ? prod_s[31:0]  : op == 3'd2 ? prod_u[31:0]  : b == '0 ? lo : quo;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (issue) begin
      count  <= is_mul ? CW'(MULT_CYC) : CW'(DIV_CYC);
      res_hi <= n_hi;
      res_lo <= n_lo;
    end else if (busy) begin
      count <= count - CW'(1);
      if (count == CW'(1)) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (mt_ok) begin
      if (op == 3'd5) hi <= a;
      if (op == 3'd6) lo <= a;
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer
module tb_mdu_sequencer;
  logic clk, reset, req, op_valid, d_md_use, busy, stall;
  logic [2:0] op;
  logic [31:0] a, b, hi, lo;
  logic [31:0] m_hi, m_lo;
  logic [63:0] sb_q[$];
  logic [63:0] e;
  int total, bad, nb;

  mdu_sequencer #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .req(req), .op_valid(op_valid), .op(op),
    .a(a), .b(b), .d_md_use(d_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y, ph, pl);
    longint sa, sb, q, r;
    logic [63:0] ux, uy, res;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    res = {ph, pl};
    case (o)
      3'd1: res = 64'(sa * sb);
      3'd2: res = ux * uy;
      3'd3: if (y != 0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd4: if (y != 0) res = {32'(ux % uy), 32'(ux / uy)};
      default: res = {ph, pl};
    endcase
    return res;
  endfunction

  task automatic exec(input logic [2:0] o, input logic [31:0] x, y, output int n);
    logic [63:0] ex;
    ex = model(o, x, y, m_hi, m_lo);
    sb_q.push_back(ex);
    {m_hi, m_lo} = ex;
    op_valid = 1; op = o; a = x; b = y;
    @(negedge clk);
    op_valid = 0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] x, input logic r);
    op_valid = 1; op = o; a = x; req = r;
    if (!r && o == 3'd5) m_hi = x;
    if (!r && o == 3'd6) m_lo = x;
    @(negedge clk);
    op_valid = 0; req = 0;
  endtask

  task automatic test_reset;
    reset = 1; req = 0; op_valid = 0; op = 0; a = 0; b = 0; d_md_use = 1;
    m_hi = 0; m_lo = 0;
    @(negedge clk);
    total++;
    if (busy !== 0 || hi !== 0 || lo !== 0 || stall !== 0) begin
      bad++;
      $display("FAIL reset_state busy=%b stall=%b hi=%h lo=%h required 0 0 0 0", busy, stall, hi, lo);
    end
    reset = 0;
    #1;
    total++;
    if (stall !== 0) begin bad++; $display("FAIL release_stall got=%b required 0", stall); end
    d_md_use = 0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    exec(3'd1, 32'hFFFF_FFFE, 32'd3, nb);
    e = sb_q.pop_front();
    total++;
    if (nb !== 5 || {hi, lo} !== e || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      bad++; $display("FAIL mult busy=%0d hi_lo=%h required 5 %h", nb, {hi, lo}, e);
    end
    exec(3'd2, 32'hFFFF_FFFE, 32'd3, nb);
    e = sb_q.pop_front();
    total++;
    if (nb !== 5 || {hi, lo} !== e || {hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin
      bad++; $display("FAIL multu busy=%0d hi_lo=%h required 5 %h", nb, {hi, lo}, e);
    end
  endtask

  task automatic test_div;
    exec(3'd3, -32'sd7, 32'd2, nb);
    e = sb_q.pop_front();
    total++;
    if (nb !== 10 || {hi, lo} !== e || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      bad++; $display("FAIL div busy=%0d hi_lo=%h required 10 %h", nb, {hi, lo}, e);
    end
    exec(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    e = sb_q.pop_front();
    total++;
    if ({hi, lo} !== e || {hi, lo} !== 64'h0000_0000_8000_0000) begin
      bad++; $display("FAIL div_overflow hi_lo=%h required %h", {hi, lo}, e);
    end
    exec(3'd4, 32'hFFFF_FFF9, 32'd2, nb);
    e = sb_q.pop_front();
    total++;
    if (nb !== 10 || {hi, lo} !== e) begin
      bad++; $display("FAIL divu busy=%0d hi_lo=%h required 10 %h", nb, {hi, lo}, e);
    end
  endtask

  task automatic test_div_zero;
    mt(3'd5, 32'h11, 0);
    mt(3'd6, 32'h22, 0);
    exec(3'd3, 32'd99, 32'd0, nb);
    e = sb_q.pop_front();
    total++;
    if (nb !== 10 || {hi, lo} !== e || {hi, lo} !== 64'h0000_0011_0000_0022) begin
      bad++; $display("FAIL div_zero busy=%0d hi_lo=%h required 10 %h", nb, {hi, lo}, e);
    end
  endtask

  task automatic test_mt;
    mt(3'd5, 32'h1234, 1);
    total++;
    if (hi !== m_hi) begin bad++; $display("FAIL mthi_req hi=%h required %h", hi, m_hi); end
    mt(3'd5, 32'h1234, 0);
    total++;
    if (hi !== 32'h1234 || busy !== 0) begin
      bad++; $display("FAIL mthi hi=%h busy=%b required 1234 0", hi, busy);
    end
    mt(3'd6, 32'h5678, 0);
    total++;
    if (lo !== 32'h5678 || hi !== 32'h1234) begin
      bad++; $display("FAIL mtlo hi=%h lo=%h required 1234 5678", hi, lo);
    end
    mt(3'd1, 32'h7, 1);
    total++;
    if (busy !== 0) begin bad++; $display("FAIL mult_req busy=%b required 0", busy); end
  endtask

  task automatic test_stall;
    d_md_use = 1;
    e = model(3'd1, 32'd5, 32'd7, m_hi, m_lo);
    {m_hi, m_lo} = e;
    op_valid = 1; op = 3'd1; a = 32'd5; b = 32'd7;
    #1;
    total++;
    if (stall !== 1) begin bad++; $display("FAIL stall_issue got=%b required 1", stall); end
    @(negedge clk);
    op_valid = 0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (stall !== 1 || busy !== 1) begin
        bad++; $display("FAIL stall_busy cyc=%0d stall=%b busy=%b required 1 1", i, stall, busy);
      end
      if (i == 1) begin op_valid = 1; op = 3'd3; a = 32'd100; b = 32'd3; end
      if (i == 2) begin op = 3'd5; a = 32'hDEAD; end
      if (i == 3) op_valid = 0;
      @(negedge clk);
    end
    total++;
    if (stall !== 0 || busy !== 0 || {hi, lo} !== e) begin
      bad++; $display("FAIL stall_after stall=%b busy=%b hi_lo=%h required 0 0 %h", stall, busy, {hi, lo}, e);
    end
    d_md_use = 0;
  endtask

  task automatic test_req_inflight;
    e = model(3'd4, 32'd1000, 32'd7, m_hi, m_lo);
    {m_hi, m_lo} = e;
    op_valid = 1; op = 3'd4; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    op_valid = 0;
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      req = (nb == 3);
      @(negedge clk);
    end
    req = 0;
    total++;
    if (nb !== 10 || {hi, lo} !== e) begin
      bad++; $display("FAIL req_inflight busy=%0d hi_lo=%h required 10 %h", nb, {hi, lo}, e);
    end
  endtask

  task automatic test_reset_mid;
    op_valid = 1; op = 3'd4; a = 32'd5000; b = 32'd3;
    @(negedge clk);
    op_valid = 0;
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1;
    total++;
    if (busy !== 0 || hi !== 0 || lo !== 0) begin
      bad++; $display("FAIL reset_mid busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
    end
    m_hi = 0; m_lo = 0;
    sb_q.delete();
    @(negedge clk);
    reset = 0;
    repeat (12) @(negedge clk);
    total++;
    if (busy !== 0 || hi !== 0 || lo !== 0) begin
      bad++; $display("FAIL reset_late_wb busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(1, 4));
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 2 == 1) y = -y;
      exec(o, x, y, nb);
      e = sb_q.pop_front();
      total++;
      if (nb !== ((o <= 3'd2) ? 5 : 10) || {hi, lo} !== e) begin
        bad++; $display("FAIL b2b op=%0d a=%h b=%h busy=%0d hi_lo=%h required %h", o, x, y, nb, {hi, lo}, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_mt;
    test_stall;
    test_req_inflight;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
